// File: rtl/booth_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_seq_mult
//
// Sequential radix-2 Booth multiplier for signed two's-complement operands.
// One Booth step is performed per clock, so a multiply takes WIDTH iteration
// cycles plus one FINISH cycle. An IDLE cycle follows before the next start
// can be accepted.
//
// Ports
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   begin a multiply (sampled only while ready=1)
//   multiplicand  in   signed M, captured on the accepted start
//   multiplier    in   signed Q, captured on the accepted start
//   ready         out  idle and able to accept start
//   busy          out  Booth iterations in progress
//   done          out  one-cycle pulse, product valid
//   product       out  signed M*Q, held stable between done pulses
// -----------------------------------------------------------------------------
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Counter must represent 0..WIDTH-1 with headroom.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // Accumulator and multiplicand carry one extra sign bit so that A-M
    // cannot overflow, even for M = -2^(WIDTH-1).
    logic [WIDTH:0]       r_a;
    logic [WIDTH:0]       r_m;
    // Multiplier extended with the implicit Q[-1] bit at the LSB.
    logic [WIDTH:0]       r_q;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic                 w_accept;
    logic                 w_last_step;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_a_shift;
    logic [WIDTH:0]       w_q_shift;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and status outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_last_step = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // -------------------------------------------------------------------------
    // Booth step: add/subtract selected by the two LSBs of Q_ext, followed by
    // an arithmetic right shift across {A, Q_ext}.
    // -------------------------------------------------------------------------
    always_comb begin
        w_sum = r_a;
        unique case (r_q[1:0])
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    assign w_a_shift = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_shift = {w_sum[0], r_q[WIDTH:1]};

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: all datapath registers are reset (not just the FSM) because the
    // product is architecturally visible and must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_m   <= {multiplicand[WIDTH-1], multiplicand};
                        r_a   <= '0;
                        r_q   <= {multiplier, 1'b0};
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_shift;
                    r_q   <= w_q_shift;
                    r_cnt <= r_cnt + 1'b1;
                    // The final step's result is captured on the edge that
                    // enters FINISH, so product is already valid while done
                    // is high.
                    if (w_last_step) begin
                        r_product <= {w_a_shift[WIDTH-1:0], w_q_shift[WIDTH:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;

endmodule
